// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: XGA raster defaults, cell geometry and the cell-position compare helper.
package vga_timing_pkg;

    localparam int H_ACTIVE = 1024;
    localparam int H_FP     = 24;
    localparam int H_SYNC   = 136;
    localparam int H_BP     = 160;
    localparam int V_ACTIVE = 768;
    localparam int V_FP     = 3;
    localparam int V_SYNC   = 6;
    localparam int V_BP     = 29;

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    localparam int CELL_W    = 32;
    localparam int CELL_H    = 48;
    localparam int X_HI_LAST = H_TOTAL / CELL_W - 1;
    localparam int Y_HI_LAST = (V_TOTAL - 1) / CELL_H;
    localparam int Y_LO_LAST = (V_TOTAL - 1) % CELL_H;

    // y is held as (cell, line-in-cell); compare lexicographically against line t
    function automatic logic y_ge(input logic [4:0] hi, input logic [5:0] lo, input int unsigned t);
        return (hi > 5'(t / CELL_H)) || (hi == 5'(t / CELL_H) && lo >= 6'(t % CELL_H));
    endfunction

endpackage

// File: rtl/vga_cell_counter.sv
// vga_cell_counter: two-digit mixed-radix counter (lo mod LO_MOD, hi up to HI_LAST) with early
// terminal lo value on the last hi cell; exposes next-state digits for aligned decoding.
module vga_cell_counter import vga_timing_pkg::*; #(
    parameter int LO_MOD             = 32,
    parameter int HI_LAST            = 41,
    parameter int LO_LAST_AT_HI_LAST = 31,
    parameter int LO_W               = $clog2(LO_MOD),
    parameter int HI_W               = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            step,
    output logic [LO_W-1:0] lo,
    output logic [HI_W-1:0] hi,
    output logic [LO_W-1:0] lo_nxt,
    output logic [HI_W-1:0] hi_nxt,
    output logic            wrap
);

    logic lo_end;

    always_comb begin
        lo_end = lo == LO_W'(LO_MOD - 1);
        wrap   = step && hi == HI_W'(HI_LAST) && lo == LO_W'(LO_LAST_AT_HI_LAST);
        lo_nxt = !step ? lo : (lo_end || wrap) ? '0 : lo + 1'b1;
        hi_nxt = !step ? hi : wrap ? '0 : lo_end ? hi + 1'b1 : hi;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lo <= '0;
            hi <= '0;
        end else begin
            lo <= lo_nxt;
            hi <= hi_nxt;
        end
    end

endmodule

// File: rtl/vga_timing_gen_xga.sv
// vga_timing_gen_xga: free-running XGA raster timing with cell-radix position, syncs, blank and
// sticky vblank interrupt. Define VGA_TIMING_FRAME_CNT_EN to enable the 8-bit frame counter.
module vga_timing_gen_xga import vga_timing_pkg::*; #(
    parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
    parameter int H_FP     = vga_timing_pkg::H_FP,
    parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
    parameter int H_BP     = vga_timing_pkg::H_BP,
    parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
    parameter int V_FP     = vga_timing_pkg::V_FP,
    parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
    parameter int V_BP     = vga_timing_pkg::V_BP
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cli,
    output logic [4:0] x_lo,
    output logic [5:0] x_hi,
    output logic [5:0] y_lo,
    output logic [4:0] y_hi,
    output logic       hsync,
    output logic       vsync,
    output logic       blank,
    output logic       interrupt,
    output logic [7:0] frame
);

    localparam int HT  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int VS0 = V_ACTIVE + V_FP;
    localparam int VS1 = VS0 + V_SYNC;
    localparam logic [10:0] HA_X  = 11'(H_ACTIVE);
    localparam logic [10:0] HS0_X = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS1_X = 11'(H_ACTIVE + H_FP + H_SYNC);

    logic [4:0]  xl_n;
    logic [5:0]  xh_n;
    logic [5:0]  yl_n;
    logic [4:0]  yh_n;
    logic [10:0] x_n;
    logic        x_wrap;
    logic        unused_y_wrap;
    logic        set_pt;

    vga_cell_counter #(
        .LO_MOD(CELL_W), .HI_LAST(HT / CELL_W - 1), .LO_LAST_AT_HI_LAST(CELL_W - 1), .HI_W(6)
    ) u_x (
        .clk(clk), .rst_n(rst_n), .step(1'b1),
        .lo(x_lo), .hi(x_hi), .lo_nxt(xl_n), .hi_nxt(xh_n), .wrap(x_wrap)
    );

    vga_cell_counter #(
        .LO_MOD(CELL_H), .HI_LAST((VT - 1) / CELL_H), .LO_LAST_AT_HI_LAST((VT - 1) % CELL_H), .HI_W(5)
    ) u_y (
        .clk(clk), .rst_n(rst_n), .step(x_wrap),
        .lo(y_lo), .hi(y_hi), .lo_nxt(yl_n), .hi_nxt(yh_n), .wrap(unused_y_wrap)
    );

    // 32-pixel cells make {hi,lo} the plain binary x
    assign x_n    = {xh_n, xl_n};
    assign set_pt = x_n == 11'd0 && yh_n == 5'(V_ACTIVE / CELL_H) && yl_n == 6'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync     <= 1'b1;
            vsync     <= 1'b1;
            blank     <= 1'b0;
            interrupt <= 1'b0;
        end else begin
            hsync     <= !(x_n >= HS0_X && x_n < HS1_X);
            vsync     <= !(y_ge(yh_n, yl_n, VS0) && !y_ge(yh_n, yl_n, VS1));
            blank     <= x_n >= HA_X || y_ge(yh_n, yl_n, V_ACTIVE);
            interrupt <= set_pt || (interrupt && !cli);
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) frame <= 8'h00;
        else if (set_pt) frame <= frame + 8'h01;
    end
`else
    assign frame = 8'h00;
`endif

endmodule
